// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bus between fetch stage (master) and memory (slave)
interface fetch_stage_if;
  logic        ihit;
  logic [31:0] iload;
  logic        imemREN;
  logic [31:0] imemaddr;
  modport master (input ihit, iload, output imemREN, imemaddr);
  modport slave (output ihit, iload, input imemREN, imemaddr);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and IF/ID register with wait-state, redirect drain, flush, stall and halt handling
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0
) (
  input  logic          CLK,
  input  logic          nRST,
  fetch_stage_if.master imem,
  input  logic          stall,
  input  logic          flush,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  input  logic          halt,
  output logic [31:0]   imemload,
  output logic [31:0]   if_id_npc,
  output logic          if_id_valid
);
  typedef enum logic [1:0] {FETCH, DRAIN, HALTED} state_t;
  state_t      state;
  logic [31:0] pc, pend_pc, pc_next4, target;
  assign pc_next4      = pc + 32'd4;
  assign target        = redirect_pc & ~32'h3;
  assign imem.imemREN  = state != HALTED;
  assign imem.imemaddr = pc;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state       <= FETCH;
      pc          <= PC_INIT;
      pend_pc     <= '0;
      imemload    <= '0;
      if_id_npc   <= '0;
      if_id_valid <= 1'b0;
    end else begin
      imemload    <= '0;
      if_id_npc   <= '0;
      if_id_valid <= 1'b0;
      case (state)
        FETCH:
          if (halt) state <= HALTED;
          else if (redirect) begin
            if (imem.ihit) pc <= target;
            else begin
              pend_pc <= target;
              state   <= DRAIN;
            end
          end else if (flush) begin
            if (imem.ihit && !stall) pc <= pc_next4;
          end else if (stall) begin
            imemload    <= imemload;
            if_id_npc   <= if_id_npc;
            if_id_valid <= if_id_valid;
          end else if (imem.ihit) begin
            imemload    <= imem.iload;
            if_id_npc   <= pc_next4;
            if_id_valid <= 1'b1;
            pc          <= pc_next4;
          end else if_id_npc <= if_id_npc;
        DRAIN:
          if (halt) state <= HALTED;
          else if (imem.ihit) begin
            pc    <= redirect ? target : pend_pc;
            state <= FETCH;
          end else if (redirect) pend_pc <= target;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage
module tb_fetch_stage;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0, stall = 1'b0, flush = 1'b0, redirect = 1'b0, halt = 1'b0;
  logic [31:0] redirect_pc = '0, imemload, if_id_npc;
  logic        if_id_valid;
  int          vectors = 0, miscompares = 0;
  typedef struct packed {logic ren; logic [31:0] addr, load, npc; logic valid;} exp_t;
  exp_t        sb[$];
  localparam logic [31:0] W1 = 32'h20010005, W2 = 32'h8C220004, W3 = 32'hAC230008, W4 = 32'h10000003;
  fetch_stage_if imem();
  fetch_stage #(.PC_INIT(32'h0)) dut (
    .CLK(CLK), .nRST(nRST), .imem(imem), .stall(stall), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .imemload(imemload), .if_id_npc(if_id_npc), .if_id_valid(if_id_valid)
  );
  always #5 CLK = ~CLK;
  function automatic exp_t mk(logic ren, logic [31:0] addr, logic [31:0] load, logic [31:0] npc, logic valid);
    exp_t x;
    x.ren = ren; x.addr = addr; x.load = load; x.npc = npc; x.valid = valid;
    return x;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic compare(string tag);
    exp_t x;
    x = sb.pop_front();
    chk({tag, ".imemREN"}, {31'b0, imem.imemREN}, {31'b0, x.ren});
    chk({tag, ".imemaddr"}, imem.imemaddr, x.addr);
    chk({tag, ".imemload"}, imemload, x.load);
    chk({tag, ".if_id_npc"}, if_id_npc, x.npc);
    chk({tag, ".if_id_valid"}, {31'b0, if_id_valid}, {31'b0, x.valid});
  endtask
  task automatic step(string tag, logic ih, logic [31:0] il, logic st, logic fl, logic rd, logic [31:0] rpc, logic hl, exp_t x);
    imem.ihit = ih; imem.iload = il; stall = st; flush = fl; redirect = rd; redirect_pc = rpc; halt = hl;
    sb.push_back(x);
    @(posedge CLK);
    @(negedge CLK);
    compare(tag);
  endtask
  task automatic async_reset(string tag);
    #2 nRST = 1'b0;
    #1 sb.push_back(mk(1, 32'h0, 32'h0, 32'h0, 0));
    compare(tag);
    @(negedge CLK);
    nRST = 1'b1;
  endtask
  initial begin
    imem.ihit = 1'b0;
    imem.iload = '0;
    repeat (2) @(negedge CLK);
    sb.push_back(mk(1, 32'h0, 32'h0, 32'h0, 0));
    compare("reset");
    nRST = 1'b1;
    step("fetch0", 1, W1, 0, 0, 0, 0, 0, mk(1, 32'h4, W1, 32'h4, 1));
    step("fetch4", 1, W1, 0, 0, 0, 0, 0, mk(1, 32'h8, W1, 32'h8, 1));
    for (int i = 0; i < 3; i++) step("wait", 0, W2, 0, 0, 0, 0, 0, mk(1, 32'h8, 32'h0, 32'h8, 0));
    step("wait_done", 1, W2, 0, 0, 0, 0, 0, mk(1, 32'hC, W2, 32'hC, 1));
    step("redir_hit", 1, W3, 0, 0, 1, 32'h103, 0, mk(1, 32'h100, 0, 0, 0));
    step("redir_to10", 1, W3, 0, 0, 1, 32'h13, 0, mk(1, 32'h10, 0, 0, 0));
    step("redir_miss", 0, W3, 0, 0, 1, 32'h103, 0, mk(1, 32'h10, 0, 0, 0));
    step("drain_wait", 0, W3, 0, 0, 0, 0, 0, mk(1, 32'h10, 0, 0, 0));
    step("drain_hit", 1, W4, 0, 0, 0, 0, 0, mk(1, 32'h100, 0, 0, 0));
    step("fetch100", 1, W1, 0, 0, 0, 0, 0, mk(1, 32'h104, W1, 32'h104, 1));
    step("drain2", 0, W1, 0, 0, 1, 32'h200, 0, mk(1, 32'h104, 0, 0, 0));
    step("drain_same_edge", 1, W2, 1, 0, 1, 32'h303, 0, mk(1, 32'h300, 0, 0, 0));
    step("redir_1c", 1, W2, 0, 0, 1, 32'h1C, 0, mk(1, 32'h1C, 0, 0, 0));
    step("fetch1c", 1, W3, 0, 0, 0, 0, 0, mk(1, 32'h20, W3, 32'h20, 1));
    for (int i = 0; i < 2; i++) step("stall", 1, W4, 1, 0, 0, 0, 0, mk(1, 32'h20, W3, 32'h20, 1));
    step("stall_rel", 1, W4, 0, 0, 0, 0, 0, mk(1, 32'h24, W4, 32'h24, 1));
    step("flush_hit", 1, W1, 0, 1, 0, 0, 0, mk(1, 32'h28, 0, 0, 0));
    step("flush_stall", 1, W1, 1, 1, 0, 0, 0, mk(1, 32'h28, 0, 0, 0));
    step("flush_miss", 0, W1, 0, 1, 0, 0, 0, mk(1, 32'h28, 0, 0, 0));
    step("redir_top", 1, W1, 0, 0, 1, 32'hFFFFFFFF, 0, mk(1, 32'hFFFFFFFC, 0, 0, 0));
    step("wrap", 1, W2, 0, 0, 0, 0, 0, mk(1, 32'h0, W2, 32'h0, 1));
    step("after_wrap", 1, W3, 0, 0, 0, 0, 0, mk(1, 32'h4, W3, 32'h4, 1));
    step("halt", 1, W3, 0, 0, 0, 0, 1, mk(0, 32'h4, 0, 0, 0));
    step("halted_redir", 1, W3, 0, 0, 1, 32'h100, 0, mk(0, 32'h4, 0, 0, 0));
    step("halted_idle", 1, W1, 0, 0, 0, 0, 0, mk(0, 32'h4, 0, 0, 0));
    async_reset("rst_halted");
    step("post_rst", 1, W1, 0, 0, 0, 0, 0, mk(1, 32'h4, W1, 32'h4, 1));
    step("drain3", 0, W1, 0, 0, 1, 32'h40, 0, mk(1, 32'h4, 0, 0, 0));
    async_reset("rst_drain");
    step("post_rst2", 1, W4, 0, 0, 0, 0, 0, mk(1, 32'h4, W4, 32'h4, 1));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the pipelined MIPS core. It owns the program counter and issues instruction-memory reads. It absorbs memory wait states and latches each fetched word into the IF/ID register, whose `imemload` output feeds the control unit directly. It also applies redirects, flushes, stalls and halt from later stages, and drains an outstanding fetch before redirecting so the memory side never sees an abandoned request.

## Interface
Parameters:
- PC_INIT, 32'h00000000, PC value loaded on reset; bits [1:0] must be 0

Ports (clock: `CLK`, rising edge; reset: `nRST`, asynchronous, active-low):
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction memory returns `iload` valid this cycle
- iload  in  32  instruction word from memory
- imemREN  out  1  instruction read enable
- imemaddr  out  32  instruction read address
- stall  in  1  hazard unit hold: PC and IF/ID keep their values
- flush  in  1  squash IF/ID contents (jumpFlush)
- redirect  in  1  taken branch/jump; load `redirect_pc`
- redirect_pc  in  32  redirect target; bits [1:0] forced to 0
- halt  in  1  halt seen downstream; stop fetching permanently
- imemload  out  32  IF/ID instruction word to control unit
- if_id_npc  out  32  PC+4 of the instruction in IF/ID
- if_id_valid  out  1  IF/ID holds a real instruction

## Operation
- Registers: `pc`, `pend_pc`, IF/ID (`imemload`, `if_id_npc`, `if_id_valid`), 2-bit state {FETCH, DRAIN, HALTED}.
- Reset values:
  - pc=PC_INIT, pend_pc=0, state=FETCH.
  - imemload=0, if_id_npc=0, if_id_valid=0.
  - imemREN=1, imemaddr=PC_INIT.
- `imemREN` and `imemaddr` are decoded from registers only:
  - FETCH and DRAIN: imemREN=1, imemaddr=pc.
  - HALTED: imemREN=0, imemaddr=pc.
- Squash means imemload←0, if_id_npc←0, if_id_valid←0.
- Priority per edge: halt > redirect > flush > stall > normal.
- FETCH state:
  - halt: state←HALTED, squash, pc held.
  - redirect with ihit=1: pc←{redirect_pc[31:2],2'b00}, squash; the arriving word is discarded.
  - redirect with ihit=0: pend_pc←target, state←DRAIN, squash, pc held.
  - flush, no redirect: squash. If ihit=1 and stall=0, pc←pc+4 and the fetched word is dropped; otherwise pc is held.
  - stall: pc and IF/ID held. The same address is re-requested and a hit during stall is discarded.
  - ihit=1, none of the above: imemload←iload, if_id_npc←pc+4, if_id_valid←1, pc←pc+4.
  - ihit=0, none of the above: if_id_valid←0, imemload←0 (bubble), pc held.
- DRAIN state:
  - The old request is held until ihit. The returned word is always discarded.
  - A new redirect overwrites pend_pc; the newest target wins, including on the same edge as ihit.
  - On ihit: pc←pend_pc (or the same-edge redirect target), state←FETCH.
  - IF/ID stays squashed; stall is ignored.
  - halt: state←HALTED.
- HALTED state: absorbing; only nRST exits. IF/ID stays squashed and all inputs are ignored.
- Arithmetic: pc+4 is 32-bit modulo, so 32'hFFFFFFFC+4 = 0.

## Timing
- Fetch latency: an `ihit` at edge N makes the word visible on `imemload` after edge N; the control unit decodes it in cycle N+1.
- Zero-wait memory gives one instruction per cycle.
- Redirect penalty:
  - One cycle when ihit=1.
  - With a fetch outstanding: the remaining wait cycles plus one.
- No combinational path from any input to any output.
- `nRST` falling mid-DRAIN or mid-stall clears everything immediately (asynchronous). The first request after release is PC_INIT.

## Test plan
- Reset, PC_INIT=0, ihit tied 1, iload=32'h20010005 → imemaddr sequence 0,4,8; imemload=32'h20010005 and if_id_npc=4 one cycle after the first hit.
- ihit low for 3 cycles at pc=8 → imemaddr stays 8, if_id_valid=0 for 3 cycles, then the word is latched and if_id_npc=12.
- Redirect to 32'h00000103 with ihit=1 → next imemaddr=0x100 and IF/ID squashed. Redirect with ihit=0 at pc=0x10 → imemaddr stays 0x10 until ihit, that word is dropped, then imemaddr=0x100.
- stall for 2 cycles with ihit=1 at pc=0x20 → imemaddr=0x20 and IF/ID unchanged both cycles; after release the 0x20 word is latched.
- halt pulse → imemREN=0 forever and if_id_valid=0; a later redirect is ignored; nRST restores imemaddr=PC_INIT.
- pc=32'hFFFFFFFC with ihit=1 → next imemaddr=0, if_id_npc=0.
